spider_sprite_renderer: RTL
===========================

# spider_sprite_renderer

Pixel-stream consumer of the spider motion state: takes the four spider positions and alive flags and, for each VGA pixel coordinate from the display timing generator, decides whether a spider covers that pixel. It produces the spider colour for the pixel mixer. Positions are snapshotted once per frame to prevent tearing. Two-frame leg animation is stepped on a frame count, and the output is a fixed 2-cycle pipeline in the clk25 domain.

## Interface
- ANIM_PERIOD, 8: number of frame_start pulses per animation-frame toggle (≥1)
- TRANSPARENT, 12'h000: ROM colour treated as see-through
- clk25  in  1  25 MHz pixel clock
- reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- video_on  in  1  pixel_x/pixel_y are in the visible area
- pixel_x  in  10  current pixel column, 0..639
- pixel_y  in  10  current pixel row, 0..479
- spider_x_flat  in  40  spider i x at bits [10i+9:10i], top-left corner, unsigned
- spider_y_flat  in  40  spider i y, same packing
- spider_alive  in  4  bit i = spider i alive
- spider_pixel_valid  out  1  spider colour present at this pixel
- spider_rgb  out  12  {R4,G4,B4}; 0 when not valid
- spider_id  out  2  index of the spider drawn; 0 when not valid

## Operation
- Snapshot: on frame_start, latch all x, y and alive into shadow registers. All hit tests use the shadow copy only. Reset clears shadow alive to 0 and shadow x/y to 0.
- Animation: frame counter 0..ANIM_PERIOD-1, advanced on each frame_start. On wrap to 0, anim_sel toggles. Reset sets counter=0 and anim_sel=0.
- Stage 1 (hit test, per spider i):
  - hit_i = alive_i && video_on && px ≥ sx && px < sx+32 && py ≥ sy && py < sy+32.
  - Bounds use 11-bit zero-extended arithmetic, so sx ≥ 992 never wraps into column 0.
  - Priority: the lowest index that hits wins.
  - Register s1_hit, s1_id, s1_ox=(px−sx)[4:0], s1_oy=(py−sy)[4:0].
- Stage 2: ROM address = {anim_sel, s1_oy, s1_ox}, 11 bits, synchronous read. Register the outputs:
  - valid = s1_hit_d && rom_data ≠ TRANSPARENT.
  - rgb = valid ? rom_data : 0.
  - id = valid ? s1_id_d : 0.
- No fall-through: if the winning spider is transparent at a pixel, a lower-priority spider overlapping that pixel is not shown. This is intentional.
- Partially off-screen spiders (x > 608) are clipped naturally, because pixel_x never exceeds 639.

## Timing
- Latency: inputs (pixel_x, pixel_y, video_on) at cycle N map to outputs at cycle N+2. The pipeline is free-running, with no stall.
- Snapshot and animation update: registered on the frame_start cycle and effective for pixels sampled from cycle N+1 onward.
- anim_sel is sampled in stage 2 at address formation, not stage 1.
- frame_start while video_on=1 is not expected. If it occurs, the pixel in flight in stage 1 on that cycle still uses the old snapshot.
- Reset:
  - Outputs: spider_pixel_valid=0, spider_rgb=0, spider_id=0.
  - Pipeline valid bits are cleared. Outputs stay 0 for at least 2 cycles after reset deassertion, until the first frame_start loads alive flags.
- Reset mid-frame: outputs drop to 0 on the next edge. Nothing is drawn until the next frame_start.
- ANIM_PERIOD=1: anim_sel toggles on every frame_start.

## Structure
- Package spider_pkg:
  - NUM_SPIDERS=4, SPR_W=32, SPR_H=32, COORD_W=10, RGB_W=12, ANIM_FRAMES=2.
  - TRANSPARENT default.
  - Packing helper function for the flat x/y buses. The motion-side wrapper uses the same packing.
- Sub-module spider_sprite_rom: 2048×12, synchronous read, 1-cycle latency, initialised by $readmemh("spider.mem").

## Test plan
- Single spider: reset, alive=4'b0001, x0=100, y0=50, pulse frame_start. Sweep pixel (100,50)..(131,81): valid at N+2 with ROM colour where non-transparent, id=0. Pixel (132,50) and (99,50): valid=0.
- Snapshot isolation: latch x0=100 and drive x0=200 mid-frame without frame_start. Pixel (100,50) still hits. After the next frame_start, (200,50) hits and (100,50) does not.
- Priority: spiders 1 and 3 both at (300,200), both alive. Pixel (310,210) reports id=1. Kill spider 1 and pulse frame_start: id=3.
- Edge/wrap: x2=1000, y2=10, alive. Pixel (0..31,10..41) never valid. x2=608: pixel (639,10) hits with ox=31.
- Animation: ANIM_PERIOD=2, pixel at a location whose colour differs between frames. anim_sel toggles after the 2nd and 4th frame_start, visible in rgb.
- Reset mid-stream: assert reset_n=0 while valid=1. All outputs 0 on the next edge. After release, no hit until frame_start, even with alive inputs high.

Source files
------------

// File: rtl/spider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spider_pkg
// Description : Shared constants and helpers for the spider sprite renderer.
//               Holds sprite geometry, colour width, the flat coordinate bus
//               packing helper and the sprite image definition.
// Revision    : 1.0 - initial release
// ============================================================================
package spider_pkg;

    localparam int NUM_SPIDERS = 4;
    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;
    localparam int COORD_W     = 10;
    localparam int RGB_W       = 12;
    localparam int ANIM_FRAMES = 2;

    localparam logic [RGB_W-1:0] TRANSPARENT_DEFAULT = 12'h000;

    // Derived widths: sprite offset, spider index, sprite ROM address.
    localparam int SPR_OFF_W = $clog2(SPR_W);
    localparam int ID_W      = $clog2(NUM_SPIDERS);
    localparam int ROM_AW    = $clog2(ANIM_FRAMES) + 2 * SPR_OFF_W;

    // Spider i occupies bits [COORD_W*i +: COORD_W] of the flat buses.
    function automatic logic [NUM_SPIDERS*COORD_W-1:0] pack_coords(
        input logic [COORD_W-1:0] c0,
        input logic [COORD_W-1:0] c1,
        input logic [COORD_W-1:0] c2,
        input logic [COORD_W-1:0] c3
    );
        return {c3, c2, c1, c0};
    endfunction

    // Sprite image, addressed as {anim_frame, oy, ox}. The main diagonal
    // (ox == oy) is see-through; every other texel has a non-zero red
    // nibble that identifies the animation frame, with green/blue carrying
    // the coarse row/column so each texel position is recognisable.
    function automatic logic [RGB_W-1:0] sprite_texel(input logic [ROM_AW-1:0] addr);
        logic [SPR_OFF_W-1:0] ox;
        logic [SPR_OFF_W-1:0] oy;
        logic                 frame;
        ox    = addr[SPR_OFF_W-1:0];
        oy    = addr[2*SPR_OFF_W-1:SPR_OFF_W];
        frame = addr[ROM_AW-1];
        if (ox == oy) begin
            return TRANSPARENT_DEFAULT;
        end
        return {(frame ? 4'hC : 4'h3), oy[4:1], ox[4:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spider_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module      : spider_sprite_rom
// Description : 2048 x 12 sprite image ROM, synchronous read, one cycle of
//               latency. Contents are the constant image from sprite_texel,
//               which synthesises to a ROM/LUT table.
// Ports       : clk  - pixel clock
//               addr - {anim_frame, oy[4:0], ox[4:0]}
//               data - texel colour {R4,G4,B4}, valid one cycle after addr
// Revision    : 1.0 - initial release
// ============================================================================
module spider_sprite_rom
    import spider_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [RGB_W-1:0]  data
);

    always_ff @(posedge clk) begin
        data <= sprite_texel(addr);
    end

endmodule
`default_nettype wire

// File: rtl/spider_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : spider_sprite_renderer
// Description : Per-pixel spider sprite renderer. Snapshots spider positions
//               once per frame, hit-tests the current pixel against all four
//               spiders (lowest index wins), looks up the sprite texel and
//               emits the colour two cycles after the pixel coordinate.
// Ports       : clk25, reset_n (sync, active-low)
//               frame_start        - one-cycle pulse, start of vblank
//               video_on, pixel_x, pixel_y - current pixel from timing gen
//               spider_x_flat / spider_y_flat / spider_alive - motion state
//               spider_pixel_valid, spider_rgb, spider_id - to pixel mixer
// Revision    : 1.0 - initial release
// ============================================================================
module spider_sprite_renderer
    import spider_pkg::*;
#(
    parameter int               ANIM_PERIOD = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic                           clk25,
    input  logic                           reset_n,
    input  logic                           frame_start,
    input  logic                           video_on,
    input  logic [COORD_W-1:0]             pixel_x,
    input  logic [COORD_W-1:0]             pixel_y,
    input  logic [NUM_SPIDERS*COORD_W-1:0] spider_x_flat,
    input  logic [NUM_SPIDERS*COORD_W-1:0] spider_y_flat,
    input  logic [NUM_SPIDERS-1:0]         spider_alive,
    output logic                           spider_pixel_valid,
    output logic [RGB_W-1:0]               spider_rgb,
    output logic [ID_W-1:0]                spider_id
);

    localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    // ------------------------------------------------------------------
    // Per-frame snapshot of the motion state (prevents tearing)
    // ------------------------------------------------------------------
    logic [NUM_SPIDERS*COORD_W-1:0] shadow_x;
    logic [NUM_SPIDERS*COORD_W-1:0] shadow_y;
    logic [NUM_SPIDERS-1:0]         shadow_alive;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_alive <= '0;
        end else if (frame_start) begin
            shadow_x     <= spider_x_flat;
            shadow_y     <= spider_y_flat;
            shadow_alive <= spider_alive;
        end
    end

    // ------------------------------------------------------------------
    // Leg animation: toggle the image frame every ANIM_PERIOD frames
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt;
    logic             anim_sel;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            anim_sel  <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(ANIM_PERIOD - 1)) begin
                frame_cnt <= '0;
                anim_sel  <= ~anim_sel;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test. Comparisons are done one bit wider than the
    // coordinates so sx + SPR_W cannot wrap back into low columns.
    // ------------------------------------------------------------------
    logic [COORD_W:0]       px_ext;
    logic [COORD_W:0]       py_ext;
    logic [NUM_SPIDERS-1:0] hit;
    logic [SPR_OFF_W-1:0]   off_x [NUM_SPIDERS];
    logic [SPR_OFF_W-1:0]   off_y [NUM_SPIDERS];

    assign px_ext = {1'b0, pixel_x};
    assign py_ext = {1'b0, pixel_y};

    generate
        for (genvar i = 0; i < NUM_SPIDERS; i++) begin : g_hit
            logic [COORD_W:0] sx_ext;
            logic [COORD_W:0] sy_ext;

            assign sx_ext = {1'b0, shadow_x[i*COORD_W +: COORD_W]};
            assign sy_ext = {1'b0, shadow_y[i*COORD_W +: COORD_W]};

            assign hit[i] = shadow_alive[i] && video_on
                         && (px_ext >= sx_ext) && (px_ext < sx_ext + (COORD_W+1)'(SPR_W))
                         && (py_ext >= sy_ext) && (py_ext < sy_ext + (COORD_W+1)'(SPR_H));

            // Only the low bits matter; they are meaningful only when hit[i].
            assign off_x[i] = SPR_OFF_W'(pixel_x - shadow_x[i*COORD_W +: COORD_W]);
            assign off_y[i] = SPR_OFF_W'(pixel_y - shadow_y[i*COORD_W +: COORD_W]);
        end
    endgenerate

    logic                 win_hit;
    logic [ID_W-1:0]      win_id;
    logic [SPR_OFF_W-1:0] win_ox;
    logic [SPR_OFF_W-1:0] win_oy;

    // Scan from the highest index down so the lowest hitting index is the
    // last one written and therefore wins.
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        win_ox  = '0;
        win_oy  = '0;
        for (int i = NUM_SPIDERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_hit = 1'b1;
                win_id  = ID_W'(i);
                win_ox  = off_x[i];
                win_oy  = off_y[i];
            end
        end
    end

    logic                 s1_hit;
    logic [ID_W-1:0]      s1_id;
    logic [SPR_OFF_W-1:0] s1_ox;
    logic [SPR_OFF_W-1:0] s1_oy;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            s1_hit <= 1'b0;
            s1_id  <= '0;
            s1_ox  <= '0;
            s1_oy  <= '0;
        end else begin
            s1_hit <= win_hit;
            s1_id  <= win_id;
            s1_ox  <= win_ox;
            s1_oy  <= win_oy;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: texel lookup. anim_sel is taken here, at address time.
    // The ROM data register and s2_* together form the output register;
    // the outputs below are pure gating of those flops.
    // ------------------------------------------------------------------
    logic [ROM_AW-1:0] rom_addr;
    logic [RGB_W-1:0]  rom_data;
    logic              s2_hit;
    logic [ID_W-1:0]   s2_id;

    assign rom_addr = {anim_sel, s1_oy, s1_ox};

    spider_sprite_rom u_rom (
        .clk  (clk25),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            s2_hit <= 1'b0;
            s2_id  <= '0;
        end else begin
            s2_hit <= s1_hit;
            s2_id  <= s1_id;
        end
    end

    // A transparent texel of the winning spider blanks the pixel outright;
    // lower-priority spiders underneath are deliberately not shown.
    assign spider_pixel_valid = s2_hit && (rom_data != TRANSPARENT);
    assign spider_rgb         = spider_pixel_valid ? rom_data : '0;
    assign spider_id          = spider_pixel_valid ? s2_id : '0;

endmodule
`default_nettype wire
